// File: rtl/axis_sync_fifo.sv
// ----------------------------------------------------------------------------
// axis_sync_fifo
//
// Single-clock AXI-Stream FIFO with first-word-fall-through read-out. Each
// entry holds tdata plus its tlast bit. Sits between the command ingress
// stream and the I2C master core.
//
// Ports
//   clk            : rising-edge clock
//   arst           : asynchronous, active-low reset
//   flush          : synchronous clear of contents (wins over push and pop)
//   s_axis_tdata   : write data
//   s_axis_tlast   : end-of-packet marker stored with the data
//   s_axis_tvalid  : write request
//   s_axis_tready  : FIFO can accept a word (not full)
//   m_axis_tdata   : head-of-FIFO data (valid while m_axis_tvalid)
//   m_axis_tlast   : tlast of the head entry
//   m_axis_tvalid  : head entry is valid (not empty)
//   m_axis_tready  : downstream consumes the head
//   level          : current occupancy, 0..FIFO_DEPTH
//   almost_full    : level >= ALMOST_FULL_LVL
//   almost_empty   : level <= ALMOST_EMPTY_LVL
// ----------------------------------------------------------------------------
module axis_sync_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int ALMOST_FULL_LVL  = FIFO_DEPTH - 1,
  parameter int ALMOST_EMPTY_LVL = 1,
  localparam int LW              = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int AW = LW - 1;
  localparam logic [LW-1:0] AF_LVL = LW'(ALMOST_FULL_LVL);
  localparam logic [LW-1:0] AE_LVL = LW'(ALMOST_EMPTY_LVL);

  // Storage: one tlast bit on top of the data word. Contents are never reset.
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

  // Pointers carry one extra wrap bit above the array index so that full and
  // empty can be told apart when the index bits match.
  logic [LW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [LW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0] level_reg, level_next;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [DATA_WIDTH:0] head_word;

  assign wr_idx = wr_ptr_reg[AW-1:0];
  assign rd_idx = rd_ptr_reg[AW-1:0];

  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  // tready depends only on the registered full flag: a pop from full does
  // not open the slot to a write in the same cycle.
  assign s_axis_tready = !full;
  assign m_axis_tvalid = !empty;

  // A flush cycle performs neither a push nor a pop; any offered word is lost.
  assign push = s_axis_tvalid && s_axis_tready && !flush;
  assign pop  = m_axis_tvalid && m_axis_tready && !flush;

  // First-word-fall-through: the head entry is read combinationally, so it
  // stays stable while the consumer stalls and the read pointer is parked.
  assign head_word    = mem[rd_idx];
  assign m_axis_tdata = head_word[DATA_WIDTH-1:0];
  assign m_axis_tlast = head_word[DATA_WIDTH];

  assign level        = level_reg;
  assign almost_full  = (level_reg >= AF_LVL);
  assign almost_empty = (level_reg <= AE_LVL);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + LW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + LW'(1);
      end
      if (push && !pop) begin
        level_next = level_reg + LW'(1);
      end else if (pop && !push) begin
        level_next = level_reg - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= {s_axis_tlast, s_axis_tdata};
    end
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_axis_sync_fifo
//
// Self-checking bench for axis_sync_fifo (DATA_WIDTH=16, FIFO_DEPTH=4,
// ALMOST_FULL_LVL=3, ALMOST_EMPTY_LVL=1). Accepted words are pushed onto a
// scoreboard queue; every word the FIFO hands out is popped and compared.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_axis_sync_fifo;

  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          arst;
  logic          flush;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [LW-1:0] level;
  logic          af;
  logic          ae;

  int checks = 0;
  int errors = 0;

  logic [DW:0] sb[$];

  axis_sync_fifo #(
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH      (DEPTH),
    .ALMOST_FULL_LVL (3),
    .ALMOST_EMPTY_LVL(1)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .flush        (flush),
    .s_axis_tdata (s_tdata),
    .s_axis_tlast (s_tlast),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tlast (m_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .level        (level),
    .almost_full  (af),
    .almost_empty (ae)
  );

  always #5 clk = ~clk;

  // Records the handshakes about to happen on the next rising edge, pushes
  // accepted stimulus onto the scoreboard, then advances to the falling edge.
  task automatic clk_edge(output logic pushed, output logic popped,
                          output logic [DW:0] pword);
    #1;
    pushed = s_tvalid && s_tready && !flush;
    popped = m_tvalid && m_tready && !flush;
    pword  = {m_tlast, m_tdata};
    if (pushed) sb.push_back({s_tlast, s_tdata});
    if (pushed || popped)
      $display("xfer t=%0t push=%0b pop=%0b out=%h level=%0d", $time, pushed, popped, pword, level);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [DW:0] sb_take();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b want 1", s_tready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (ae !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", ae); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", af); end
    @(negedge clk);
    arst = 1'b1;
  endtask

  task automatic test_fill();
    logic pu, po;
    logic [DW:0] pw;
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = DW'(16'h1111 * (i + 1));
      s_tlast  = 1'b0;
      clk_edge(pu, po, pw);
      checks++; if (level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level: got %0d want %0d", level, i + 1); end
      checks++; if (af !== ((i + 1) >= 3)) begin errors++; $display("FAIL fill_almost_full: got %b at level %0d", af, i + 1); end
      checks++; if (ae !== ((i + 1) <= 1)) begin errors++; $display("FAIL fill_almost_empty: got %b at level %0d", ae, i + 1); end
      checks++; if (m_tdata !== 16'h1111) begin errors++; $display("FAIL fill_head: got %h want 1111", m_tdata); end
    end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL full_tready: got %b want 0", s_tready); end
    s_tdata = 16'h5555;
    clk_edge(pu, po, pw);
    checks++; if (pu !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL full_no_accept: pushed %b level %0d want 0/4", pu, level); end
    checks++; if (m_tdata !== 16'h1111) begin errors++; $display("FAIL full_head: got %h want 1111", m_tdata); end
  endtask

  task automatic test_drain();
    logic pu, po, got5;
    logic [DW:0] pw, exp;
    got5 = 1'b0;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 16'h5555;
    for (int c = 0; c < 12 && (sb.size() > 0 || !got5); c++) begin
      clk_edge(pu, po, pw);
      if (pu) begin
        got5 = 1'b1;
        s_tvalid = 1'b0;
        checks++; if (c != 1) begin errors++; $display("FAIL drain_push_cycle: got %0d want 1", c); end
      end
      if (po) begin
        exp = sb_take();
        checks++; if (pw !== exp) begin errors++; $display("FAIL drain_data: got %h want %h", pw, exp); end
      end
    end
    checks++; if (!got5 || sb.size() != 0) begin errors++; $display("FAIL drain_done: pushed5 %b left %0d want 1/0", got5, sb.size()); end
    checks++; if (m_tvalid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL drain_empty: tvalid %b level %0d want 0/0", m_tvalid, level); end
    checks++; if (ae !== 1'b1) begin errors++; $display("FAIL drain_almost_empty: got %b want 1", ae); end
  endtask

  task automatic test_stream();
    logic pu, po;
    logic [DW:0] pw, exp;
    int i, outs;
    i = 0; outs = 0;
    m_tready = 1'b1;
    for (int c = 0; c < 24 && (i < 12 || sb.size() > 0); c++) begin
      s_tvalid = (i < 12);
      s_tdata  = DW'(i);
      s_tlast  = ((i % 4) == 3);
      clk_edge(pu, po, pw);
      if (pu) i++;
      if (po) begin
        outs++;
        exp = sb_take();
        checks++; if (pw !== exp) begin errors++; $display("FAIL stream_data: got %h want %h", pw, exp); end
      end
      checks++; if (level > 3'd1) begin errors++; $display("FAIL stream_level: got %0d want <=1", level); end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    checks++; if (outs != 12) begin errors++; $display("FAIL stream_count: got %0d want 12", outs); end
  endtask

  task automatic test_simul();
    logic pu, po;
    logic [DW:0] pw, exp;
    m_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(16'hA001 + i);
      clk_edge(pu, po, pw);
    end
    checks++; if (level !== 3'd2 || ae !== 1'b0) begin errors++; $display("FAIL simul_pre: level %0d ae %b want 2/0", level, ae); end
    m_tready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      s_tdata = DW'(16'hA001 + i);
      clk_edge(pu, po, pw);
      checks++; if (!(pu && po)) begin errors++; $display("FAIL simul_both: push %b pop %b want 1/1", pu, po); end
      if (po) begin
        exp = sb_take();
        checks++; if (pw !== exp) begin errors++; $display("FAIL simul_data: got %h want %h", pw, exp); end
      end
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL simul_level: got %0d want 2", level); end
    end
    s_tvalid = 1'b0;
    for (int c = 0; c < 8 && sb.size() > 0; c++) begin
      clk_edge(pu, po, pw);
      if (po) begin
        exp = sb_take();
        checks++; if (pw !== exp) begin errors++; $display("FAIL simul_drain: got %h want %h", pw, exp); end
      end
    end
    checks++; if (sb.size() != 0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL simul_end: left %0d tvalid %b want 0/0", sb.size(), m_tvalid); end
  endtask

  task automatic test_flush();
    logic pu, po;
    logic [DW:0] pw;
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(16'hC001 + i);
      clk_edge(pu, po, pw);
    end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL flush_pre: level %0d want 3", level); end
    flush = 1'b1; s_tdata = 16'hAAAA;
    clk_edge(pu, po, pw);
    flush = 1'b0; s_tvalid = 1'b0;
    sb.delete();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_level: got %0d want 0", level); end
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL flush_flags: tvalid %b tready %b want 0/1", m_tvalid, s_tready); end
    checks++; if (ae !== 1'b1 || af !== 1'b0) begin errors++; $display("FAIL flush_almost: ae %b af %b want 1/0", ae, af); end
    m_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      clk_edge(pu, po, pw);
      checks++; if (po) begin errors++; $display("FAIL flush_leak: got %h want no output", pw); end
    end
  endtask

  task automatic test_async_reset();
    logic pu, po;
    logic [DW:0] pw, exp;
    m_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(16'hD001 + i);
      clk_edge(pu, po, pw);
    end
    s_tvalid = 1'b0;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL arst_pre: level %0d want 2", level); end
    #2;
    arst = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL arst_flags: tvalid %b tready %b want 0/1", m_tvalid, s_tready); end
    checks++; if (level !== 3'd0 || ae !== 1'b1 || af !== 1'b0) begin errors++; $display("FAIL arst_level: level %0d ae %b af %b want 0/1/0", level, ae, af); end
    sb.delete();
    @(negedge clk);
    arst = 1'b1;
    s_tvalid = 1'b1; s_tdata = 16'hBEEF; s_tlast = 1'b1;
    clk_edge(pu, po, pw);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== 17'h1BEEF) begin errors++; $display("FAIL arst_first: tvalid %b word %h want 1/1beef", m_tvalid, {m_tlast, m_tdata}); end
    m_tready = 1'b1;
    clk_edge(pu, po, pw);
    exp = sb_take();
    checks++; if (!po || pw !== exp) begin errors++; $display("FAIL arst_pop: pop %b got %h want %h", po, pw, exp); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL arst_empty: tvalid %b want 0", m_tvalid); end
  endtask

  initial begin
    arst = 1'b0; flush = 1'b0;
    s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_simul();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/axis_sync_fifo.md
# axis_sync_fifo

Parametrised single-clock AXI-Stream FIFO that supersedes the plain `sync_fifo` enable/flag interface. It uses valid/ready handshakes on both sides, carries `tlast` alongside the data, and reads out in first-word-fall-through fashion. It also reports occupancy, almost-full/almost-empty status and supports a synchronous flush. It sits between the AXI-Stream command ingress and the I2C master core, buffering command/data words.

## Interface

- `DATA_WIDTH`, 8: `tdata` width in bits; `tlast` is stored as one extra bit per entry.
- `FIFO_DEPTH`, 16: number of entries; power of two, minimum 2.
- `ALMOST_FULL_LVL`, `FIFO_DEPTH-1`: `almost_full` asserts when level ≥ this value; range 1..`FIFO_DEPTH`.
- `ALMOST_EMPTY_LVL`, 1: `almost_empty` asserts when level ≤ this value; range 0..`FIFO_DEPTH-1`.

Ports (LW = $clog2(`FIFO_DEPTH`)+1):

- `clk` in 1: single clock; all logic is rising-edge.
- `arst` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of contents.
- `s_axis_tdata` in `DATA_WIDTH`: write data.
- `s_axis_tlast` in 1: end-of-packet marker, stored with the data.
- `s_axis_tvalid` in 1: write request.
- `s_axis_tready` out 1: FIFO can accept a word.
- `m_axis_tdata` out `DATA_WIDTH`: head-of-FIFO data.
- `m_axis_tlast` out 1: `tlast` of the head entry.
- `m_axis_tvalid` out 1: head entry is valid.
- `m_axis_tready` in 1: downstream consumes the head.
- `level` out LW: current occupancy, 0..`FIFO_DEPTH`.
- `almost_full` out 1: level ≥ `ALMOST_FULL_LVL`.
- `almost_empty` out 1: level ≤ `ALMOST_EMPTY_LVL`.

## Operation

- Storage is a `FIFO_DEPTH` x (`DATA_WIDTH`+1) array.
- Write pointer and read pointer are each LW bits wide. The low $clog2(`FIFO_DEPTH`) bits index the array; the MSB is the wrap bit.
- Full: pointer MSBs differ and the index bits are equal.
- Empty: the two pointers are equal.
- Push = `s_axis_tvalid` & `s_axis_tready`. Writes the entry at the write pointer, then the write pointer increments.
- Pop = `m_axis_tvalid` & `m_axis_tready`. The read pointer increments.
- `level` is a register:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- `s_axis_tready` = !full. When full there is no write-through, even if a pop happens in the same cycle; the freed slot becomes writable on the next cycle.
- `m_axis_tvalid` = !empty. `m_axis_tdata`/`m_axis_tlast` read the array at the read pointer asynchronously (FWFT).
  - When `m_axis_tvalid`=0, the data outputs are don't-care.
  - While `m_axis_tvalid`=1 and `m_axis_tready`=0, the data outputs hold stable (AXI-Stream rule).
- Simultaneous push and pop are legal at any level except: at level 0 only push can occur, and at level `FIFO_DEPTH` only pop can occur.
- `flush`=1 has priority over push and pop. On the next edge both pointers and `level` return to 0. A push presented in the flush cycle is dropped.
- Pointers wrap naturally modulo 2·`FIFO_DEPTH`; no special case is needed.
- Array contents are not reset.

## Timing

- Reset (`arst`=0), asynchronous and immediate:
  - Pointers = 0 and `level` = 0.
  - `m_axis_tvalid` = 0, `s_axis_tready` = 1.
  - `almost_empty` = 1 (since `ALMOST_EMPTY_LVL` ≥ 0).
  - `almost_full` = 0.
- Reset deassertion is taken synchronously by the first rising edge after release.
- Write-to-read latency is 1 cycle: a push at edge N gives `m_axis_tvalid`=1 with that data immediately after edge N.
- `s_axis_tready` drops immediately after the edge that fills the last slot. It rises immediately after the edge of the first pop from full.
- `level`, `almost_full` and `almost_empty` update after the same edge as the push/pop/flush that changes them.
- Reset asserted mid-transfer discards all contents. The in-flight handshake in that cycle is lost.
- Sustained throughput: 1 word/cycle when neither full nor empty.

## Test plan

Parameters for all scenarios: `DATA_WIDTH`=16, `FIFO_DEPTH`=4, `ALMOST_FULL_LVL`=3, `ALMOST_EMPTY_LVL`=1.

1. **Fill with reader stalled.** Write 0x1111, 0x2222, 0x3333, 0x4444 with `m_axis_tready`=0 and hold `tvalid` for a 5th word 0x5555.
   - `level` goes 1,2,3,4.
   - `almost_full`=1 at level 3.
   - `s_axis_tready`=0 after the 4th edge; 0x5555 is not accepted.
   - `m_axis_tdata`=0x1111 throughout.
2. **Drain.** From full, `m_axis_tready`=1.
   - Output 0x1111..0x4444 on consecutive cycles, then `m_axis_tvalid`=0, `level`=0, `almost_empty`=1.
   - 0x5555 is pushed at the first edge after the first pop and appears last.
3. **Streaming.** Both sides valid/ready for 12 cycles with tdata 0..11 and `tlast` on words 3, 7, 11.
   - Output is 0..11 in order with `tlast` on the same words.
   - `level` ≤ 1.
   - Pointers wrap at least once.
4. **Simultaneous push and pop at level 2.** `level` stays 2 and the output order is preserved.
5. **Flush.** At level 3, assert `flush` together with a push of 0xAAAA.
   - Next cycle: `level`=0, `m_axis_tvalid`=0, `s_axis_tready`=1.
   - 0xAAAA never appears on the output.
6. **Mid-operation reset.** Assert `arst`=0 asynchronously (between edges) at level 2.
   - Outputs go to their reset values without waiting for an edge.
   - After release, a fresh write of 0xBEEF is the first output, 1 cycle later.
